operand_stack: RTL and testbench
================================

Name: operand_stack

Overview:
- Hardware data stack directly upstream of the 16-bit ALU in the stack-machine datapath.
- Holds signed 16-bit operands and always presents the two top entries as ALU operands: NOS drives ALU A, TOS drives ALU B, so that "a b sub" computes a-b.
- Accepts one stack operation per clock: push, pop, dup, swap, unary replace, and binary collapse.
- Writes ALU (or other) results back via DataIn.

Parameters:
- DEPTH, 16, number of 16-bit entries; power of two, minimum 4.
- PTR_W, 4, log2(DEPTH); SP is PTR_W+1 bits wide so it can hold 0..DEPTH.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- StackOp  input  3  operation for this cycle (encodings below).
- DataIn  input  16  value written by PUSH, REPL1 and REPL2; typically the ALU result S.
- Tos  output  16  top of stack (entry SP-1), or 0 when Depth<1.
- Nos  output  16  next of stack (entry SP-2), or 0 when Depth<2.
- Depth  output  PTR_W+1  current number of valid entries.
- Empty  output  1  Depth==0.
- Full  output  1  Depth==DEPTH.
- Ovf  output  1  sticky; set when a push-type op is attempted while Full.
- Unf  output  1  sticky; set when an op needs more entries than are present.

Behaviour:
- Op encodings:
  - 000 NOP
  - 001 PUSH: needs 0 entries; net +1.
  - 010 POP: needs 1; net -1.
  - 011 DUP: needs 1; net +1.
  - 100 SWAP: needs 2; net 0.
  - 101 REPL1: needs 1; net 0. Replaces TOS with DataIn (unary ALU ops: not, neg).
  - 110 REPL2: needs 2; net -1. Pops 2, pushes DataIn (binary ALU ops).
  - 111 reserved, treated as NOP.
- All state updates on the rising CLK edge. Tos, Nos, Depth, Empty, Full, Ovf and Unf are combinational from registers only, with no path from StackOp or DataIn.
- Latency:
  - The effect of an op issued in cycle n is visible on Tos/Nos/Depth in cycle n+1.
  - The ALU result computed from cycle-n Tos/Nos can be issued as REPL2 in cycle n itself; this is the single-cycle "a b op" loop.
- Reset (synchronous, while Reset=1 at the edge): SP=0, Ovf=0, Unf=0. Outputs are then Tos=0, Nos=0, Depth=0, Empty=1, Full=0. Storage contents are not cleared and are don't-care. Reset overrides any StackOp in the same cycle.
- Underflow: if Depth is below the op's requirement, the op is dropped. No storage or SP change occurs and Unf is set.
- Overflow: PUSH or DUP while Full is dropped. No change occurs and Ovf is set.
- Ovf and Unf stay set until Reset. A later legal op still executes normally.
- SWAP exchanges entries SP-1 and SP-2 in one edge.
- REPL2 writes DataIn to entry SP-2 and sets SP=SP-1.
- DUP copies entry SP-1 into entry SP.
- SP never wraps; it is held within 0..DEPTH by the guards above.
- Reset asserted mid-sequence: the op issued in that cycle is discarded.

Decomposition:
- Shared package/header stack_defs:
  - op encoding localparams (OP_NOP … OP_REPL2)
  - WORD_W=16
- One natural sub-module, stack_regfile:
  - DEPTH x 16 register array
  - two asynchronous read ports at SP-1 and SP-2
  - two synchronous write ports, needed for SWAP
- SP/flag control and the op decode stay in operand_stack.

Test Plan:
1. Reset, then PUSH 5, PUSH 3, REPL2 with DataIn=2 (5-3) -> after the pushes Tos=3, Nos=5, Depth=2; after REPL2 Tos=2, Nos=0, Depth=1, Unf=0.
2. Tos=0x00FF at Depth=1, REPL1 with DataIn=0xFF00 -> Tos=0xFF00, Depth stays 1. Then DUP -> Tos=Nos=0xFF00, Depth=2.
3. PUSH 0x1234, PUSH 0xABCD, SWAP -> Tos=0x1234, Nos=0xABCD, Depth=2. SWAP again restores the original order.
4. DEPTH pushes of 1..16 -> Full=1, Tos=16. A 17th PUSH of 99 -> Tos=16, Depth=16, Ovf=1. Then POP -> Tos=15, Full=0, Ovf still 1.
5. From reset: POP -> Unf=1, Depth=0, Empty=1. Then PUSH 7 -> Tos=7, Depth=1. REPL2 at Depth=1 -> dropped, Tos=7, Unf=1.
6. PUSH 4, PUSH 9, then Reset asserted in the same cycle as PUSH 1 -> next cycle Depth=0, Empty=1, Tos=0, Ovf=Unf=0.

Source files
------------

// File: rtl/stack_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_defs (package)
// Description : Shared definitions for the operand stack: data word width,
//               stack operation encodings, and per-op helper functions that
//               give the number of entries an op needs and whether it grows
//               the stack.
// Revision    : 1.0 - initial release
// ============================================================================
package stack_defs;

    localparam int WORD_W = 16;

    typedef logic [2:0] stack_op_t;

    localparam stack_op_t OP_NOP   = 3'b000;
    localparam stack_op_t OP_PUSH  = 3'b001;
    localparam stack_op_t OP_POP   = 3'b010;
    localparam stack_op_t OP_DUP   = 3'b011;
    localparam stack_op_t OP_SWAP  = 3'b100;
    localparam stack_op_t OP_REPL1 = 3'b101;
    localparam stack_op_t OP_REPL2 = 3'b110;
    localparam stack_op_t OP_RSVD  = 3'b111;

    // Minimum number of valid entries an op needs before it may execute.
    function automatic logic [1:0] op_min_depth(input stack_op_t op);
        logic [1:0] need;
        need = 2'd0;
        case (op)
            OP_POP, OP_DUP, OP_REPL1: need = 2'd1;
            OP_SWAP, OP_REPL2:        need = 2'd2;
            default:                  need = 2'd0;
        endcase
        return need;
    endfunction

    // Ops whose net effect is one extra entry; these are dropped when full.
    function automatic logic op_grows(input stack_op_t op);
        return (op == OP_PUSH) || (op == OP_DUP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stack_regfile.sv
`default_nettype none
// ============================================================================
// Module      : stack_regfile
// Description : DEPTH x WORD_W storage for the operand stack. Two
//               asynchronous read ports (top / next-of-stack addresses) and
//               two synchronous write ports so SWAP completes in one edge.
// Ports       : clk          - rising-edge clock
//               we_a/addr_a/data_a - write port A
//               we_b/addr_b/data_b - write port B
//               rd_addr_top/rd_top - async read port (TOS)
//               rd_addr_nos/rd_nos - async read port (NOS)
// Revision    : 1.0 - initial release
// ============================================================================
module stack_regfile
    import stack_defs::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic              clk,
    input  logic              we_a,
    input  logic [PTR_W-1:0]  addr_a,
    input  logic [WORD_W-1:0] data_a,
    input  logic              we_b,
    input  logic [PTR_W-1:0]  addr_b,
    input  logic [WORD_W-1:0] data_b,
    input  logic [PTR_W-1:0]  rd_addr_top,
    input  logic [PTR_W-1:0]  rd_addr_nos,
    output logic [WORD_W-1:0] rd_top,
    output logic [WORD_W-1:0] rd_nos
);

    // Contents are never cleared; validity is tracked by the stack pointer.
    logic [WORD_W-1:0] mem [DEPTH];

    // The controller never issues both ports to the same address; port A is
    // written last so it would win if that ever happened.
    always_ff @(posedge clk) begin
        if (we_b) begin
            mem[addr_b] <= data_b;
        end
        if (we_a) begin
            mem[addr_a] <= data_a;
        end
    end

    assign rd_top = mem[rd_addr_top];
    assign rd_nos = mem[rd_addr_nos];

endmodule
`default_nettype wire

// File: rtl/operand_stack.sv
`default_nettype none
// ============================================================================
// Module      : operand_stack
// Description : Hardware operand stack feeding the 16-bit ALU. Presents TOS
//               (ALU B) and NOS (ALU A) combinationally from registers and
//               executes one op per clock: PUSH, POP, DUP, SWAP, REPL1,
//               REPL2. Illegal ops are dropped and flagged with sticky
//               overflow / underflow bits.
// Ports       : CLK     - rising-edge clock
//               Reset   - synchronous active-high reset
//               StackOp - operation for this cycle
//               DataIn  - value for PUSH / REPL1 / REPL2
//               Tos/Nos - top / next-of-stack (0 when not present)
//               Depth   - number of valid entries
//               Empty/Full - Depth==0 / Depth==DEPTH
//               Ovf/Unf - sticky overflow / underflow
// Revision    : 1.0 - initial release
// ============================================================================
module operand_stack
    import stack_defs::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [2:0]        StackOp,
    input  logic [WORD_W-1:0] DataIn,
    output logic [WORD_W-1:0] Tos,
    output logic [WORD_W-1:0] Nos,
    output logic [PTR_W:0]    Depth,
    output logic              Empty,
    output logic              Full,
    output logic              Ovf,
    output logic              Unf
);

    localparam logic [PTR_W:0]   SP_ZERO = '0;
    localparam logic [PTR_W:0]   SP_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   SP_TWO  = (PTR_W+1)'(2);
    localparam logic [PTR_W:0]   SP_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] AD_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] AD_TWO  = PTR_W'(2);

    // Registered state
    logic [PTR_W:0] sp;
    logic           ovf_flag;
    logic           unf_flag;

    // Combinational decode
    logic [PTR_W:0]    sp_next;
    logic              set_ovf;
    logic              set_unf;
    logic              underflow;
    logic              overflow;
    logic              is_full;
    logic [PTR_W-1:0]  addr_new;
    logic [PTR_W-1:0]  addr_top;
    logic [PTR_W-1:0]  addr_nos;
    logic [WORD_W-1:0] rd_top;
    logic [WORD_W-1:0] rd_nos;
    logic              we_a;
    logic [PTR_W-1:0]  waddr_a;
    logic [WORD_W-1:0] wdata_a;
    logic              we_b;
    logic [PTR_W-1:0]  waddr_b;
    logic [WORD_W-1:0] wdata_b;

    // Addresses wrap modulo DEPTH on purpose: when sp==DEPTH the low bits
    // are 0, so addr_top = DEPTH-1 as required, and addr_new is only used
    // when the stack is not full.
    assign addr_new = sp[PTR_W-1:0];
    assign addr_top = sp[PTR_W-1:0] - AD_ONE;
    assign addr_nos = sp[PTR_W-1:0] - AD_TWO;

    assign is_full   = (sp == SP_FULL);
    assign underflow = (sp < (PTR_W+1)'(op_min_depth(StackOp)));
    assign overflow  = op_grows(StackOp) && is_full;

    always_comb begin
        sp_next = sp;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        we_a    = 1'b0;
        waddr_a = addr_new;
        wdata_a = DataIn;
        we_b    = 1'b0;
        waddr_b = addr_nos;
        wdata_b = rd_top;

        // Underflow is checked first: an empty stack can never also be full.
        if (underflow) begin
            set_unf = 1'b1;
        end else if (overflow) begin
            set_ovf = 1'b1;
        end else begin
            case (StackOp)
                OP_PUSH: begin
                    we_a    = 1'b1;
                    waddr_a = addr_new;
                    wdata_a = DataIn;
                    sp_next = sp + SP_ONE;
                end
                OP_POP: begin
                    sp_next = sp - SP_ONE;
                end
                OP_DUP: begin
                    we_a    = 1'b1;
                    waddr_a = addr_new;
                    wdata_a = rd_top;
                    sp_next = sp + SP_ONE;
                end
                OP_SWAP: begin
                    we_a    = 1'b1;
                    waddr_a = addr_top;
                    wdata_a = rd_nos;
                    we_b    = 1'b1;
                    waddr_b = addr_nos;
                    wdata_b = rd_top;
                end
                OP_REPL1: begin
                    we_a    = 1'b1;
                    waddr_a = addr_top;
                    wdata_a = DataIn;
                end
                OP_REPL2: begin
                    we_a    = 1'b1;
                    waddr_a = addr_nos;
                    wdata_a = DataIn;
                    sp_next = sp - SP_ONE;
                end
                default: begin
                    // NOP and the reserved encoding do nothing.
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            sp       <= SP_ZERO;
            ovf_flag <= 1'b0;
            unf_flag <= 1'b0;
        end else begin
            sp       <= sp_next;
            ovf_flag <= ovf_flag | set_ovf;
            unf_flag <= unf_flag | set_unf;
        end
    end

    // Storage writes are suppressed during reset so the op issued with
    // Reset is fully discarded.
    stack_regfile #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_regfile (
        .clk         (CLK),
        .we_a        (we_a & ~Reset),
        .addr_a      (waddr_a),
        .data_a      (wdata_a),
        .we_b        (we_b & ~Reset),
        .addr_b      (waddr_b),
        .data_b      (wdata_b),
        .rd_addr_top (addr_top),
        .rd_addr_nos (addr_nos),
        .rd_top      (rd_top),
        .rd_nos      (rd_nos)
    );

    assign Tos   = (sp >= SP_ONE) ? rd_top : '0;
    assign Nos   = (sp >= SP_TWO) ? rd_nos : '0;
    assign Depth = sp;
    assign Empty = (sp == SP_ZERO);
    assign Full  = is_full;
    assign Ovf   = ovf_flag;
    assign Unf   = unf_flag;

endmodule
`default_nettype wire

// File: tb/tb_operand_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_stack
// Description : Self-checking bench for operand_stack. Directed scenarios
//               plus randomized op streams compared against a queue-based
//               reference model of the stack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_stack;
    import stack_defs::*;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic              CLK;
    logic              Reset;
    logic [2:0]        StackOp;
    logic [WORD_W-1:0] DataIn;
    logic [WORD_W-1:0] Tos;
    logic [WORD_W-1:0] Nos;
    logic [PTR_W:0]    Depth;
    logic              Empty;
    logic              Full;
    logic              Ovf;
    logic              Unf;

    operand_stack #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .StackOp (StackOp),
        .DataIn  (DataIn),
        .Tos     (Tos),
        .Nos     (Nos),
        .Depth   (Depth),
        .Empty   (Empty),
        .Full    (Full),
        .Ovf     (Ovf),
        .Unf     (Unf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: q[$] is top of stack.
    logic [15:0] q[$];
    bit          m_ovf;
    bit          m_unf;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_step(input logic [2:0] op, input logic [15:0] d, input logic rst);
        logic [15:0] t;
        logic [15:0] n;
        if (rst) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
            return;
        end
        case (op)
            OP_PUSH:  if (q.size() == DEPTH) m_ovf = 1; else q.push_back(d);
            OP_POP:   if (q.size() < 1) m_unf = 1; else void'(q.pop_back());
            OP_DUP: begin
                if (q.size() < 1) m_unf = 1;
                else if (q.size() == DEPTH) m_ovf = 1;
                else q.push_back(q[$]);
            end
            OP_SWAP: begin
                if (q.size() < 2) m_unf = 1;
                else begin
                    t = q.pop_back();
                    n = q.pop_back();
                    q.push_back(t);
                    q.push_back(n);
                end
            end
            OP_REPL1: if (q.size() < 1) m_unf = 1; else q[$] = d;
            OP_REPL2: begin
                if (q.size() < 2) m_unf = 1;
                else begin
                    void'(q.pop_back());
                    void'(q.pop_back());
                    q.push_back(d);
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all(input string tag);
        logic [15:0] e_tos;
        logic [15:0] e_nos;
        e_tos = (q.size() >= 1) ? q[$] : 16'h0;
        e_nos = (q.size() >= 2) ? q[$-1] : 16'h0;
        check({tag, "_tos"},   32'(Tos),   32'(e_tos));
        check({tag, "_nos"},   32'(Nos),   32'(e_nos));
        check({tag, "_depth"}, 32'(Depth), 32'(q.size()));
        check({tag, "_empty"}, 32'(Empty), 32'(q.size() == 0));
        check({tag, "_full"},  32'(Full),  32'(q.size() == DEPTH));
        check({tag, "_ovf"},   32'(Ovf),   32'(m_ovf));
        check({tag, "_unf"},   32'(Unf),   32'(m_unf));
    endtask

    // Apply one op for one clock, advance the model, then check after the edge.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] d, input logic rst);
        StackOp = op;
        DataIn  = d;
        Reset   = rst;
        @(posedge CLK);
        model_step(op, d, rst);
        #1;
        Reset   = 1'b0;
        StackOp = OP_NOP;
        DataIn  = 16'h0;
        compare_all(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        StackOp = OP_NOP;
        DataIn  = 16'h0;
        Reset   = 1'b1;
        m_ovf   = 0;
        m_unf   = 0;

        // Reset state
        do_op("reset", OP_NOP, 16'h0, 1'b1);
        check("reset_empty_const", 32'(Empty), 32'd1);

        // 1: a b sub loop
        do_op("t1_push5", OP_PUSH, 16'd5, 1'b0);
        do_op("t1_push3", OP_PUSH, 16'd3, 1'b0);
        check("t1_nos_const", 32'(Nos), 32'd5);
        do_op("t1_repl2", OP_REPL2, 16'd2, 1'b0);
        check("t1_tos_const", 32'(Tos), 32'd2);
        check("t1_depth_const", 32'(Depth), 32'd1);

        // 2: REPL1 then DUP
        do_op("t2_rst", OP_NOP, 16'h0, 1'b1);
        do_op("t2_push", OP_PUSH, 16'h00FF, 1'b0);
        do_op("t2_repl1", OP_REPL1, 16'hFF00, 1'b0);
        check("t2_tos_const", 32'(Tos), 32'hFF00);
        do_op("t2_dup", OP_DUP, 16'h0, 1'b0);
        check("t2_nos_const", 32'(Nos), 32'hFF00);

        // 3: SWAP twice
        do_op("t3_rst", OP_NOP, 16'h0, 1'b1);
        do_op("t3_pa", OP_PUSH, 16'h1234, 1'b0);
        do_op("t3_pb", OP_PUSH, 16'hABCD, 1'b0);
        do_op("t3_swap1", OP_SWAP, 16'h0, 1'b0);
        check("t3_tos_const", 32'(Tos), 32'h1234);
        do_op("t3_swap2", OP_SWAP, 16'h0, 1'b0);
        check("t3_tos2_const", 32'(Tos), 32'hABCD);

        // 4: fill, overflow, pop
        do_op("t4_rst", OP_NOP, 16'h0, 1'b1);
        for (int i = 1; i <= DEPTH; i++) do_op("t4_fill", OP_PUSH, 16'(i), 1'b0);
        check("t4_full_const", 32'(Full), 32'd1);
        do_op("t4_ovf_push", OP_PUSH, 16'd99, 1'b0);
        check("t4_tos_const", 32'(Tos), 32'd16);
        check("t4_ovf_const", 32'(Ovf), 32'd1);
        do_op("t4_ovf_dup", OP_DUP, 16'h0, 1'b0);
        do_op("t4_pop", OP_POP, 16'h0, 1'b0);
        check("t4_tos15_const", 32'(Tos), 32'd15);

        // 5: underflow handling
        do_op("t5_rst", OP_NOP, 16'h0, 1'b1);
        do_op("t5_pop", OP_POP, 16'h0, 1'b0);
        check("t5_unf_const", 32'(Unf), 32'd1);
        do_op("t5_push", OP_PUSH, 16'd7, 1'b0);
        do_op("t5_repl2", OP_REPL2, 16'd55, 1'b0);
        check("t5_tos_const", 32'(Tos), 32'd7);
        do_op("t5_swap", OP_SWAP, 16'h0, 1'b0);

        // 6: reset overriding a push
        do_op("t6_rst", OP_NOP, 16'h0, 1'b1);
        do_op("t6_p4", OP_PUSH, 16'd4, 1'b0);
        do_op("t6_p9", OP_PUSH, 16'd9, 1'b0);
        do_op("t6_rst_push", OP_PUSH, 16'd1, 1'b1);
        check("t6_depth_const", 32'(Depth), 32'd0);

        // Random streams; phases alternate between growing and shrinking
        // so the full and empty boundaries are both exercised.
        for (int i = 0; i < 1500; i++) begin
            logic [2:0]  op;
            logic [15:0] d;
            int          r;
            r = $urandom_range(0, 99);
            d = 16'($urandom);
            if (((i / 120) % 2) == 0) begin
                if (r < 45)      op = OP_PUSH;
                else if (r < 60) op = OP_DUP;
                else             op = 3'($urandom_range(0, 7));
            end else begin
                if (r < 35)      op = OP_POP;
                else if (r < 55) op = OP_REPL2;
                else             op = 3'($urandom_range(0, 7));
            end
            do_op("rand", op, d, ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
